// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M-style multiply/divide unit with valid/ready handshakes
//
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   rs1, rs2_MUX          operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   MulCtrl               000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   out_valid / out_ready result handshake
//   result, zero, div_by_zero  registered result and flags, valid while out_valid
module muldiv_seq #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] rs1,
    input  logic [width-1:0] rs2_MUX,
    input  logic [2:0]       MulCtrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int cw = $clog2(width);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic [2:0]       op_q;
    logic             neg_a, neg_b;
    logic [width-1:0] opnd;     // multiplicand (mul) or divisor magnitude (div)
    logic [width-1:0] acc_hi;   // product high half / partial remainder
    logic [width-1:0] acc_lo;   // multiplier being consumed / dividend becoming quotient
    logic [cw-1:0]    cnt;

    // Operand decode at accept
    logic             rs1_signed, rs2_signed;
    logic             sign_a, sign_b;
    logic [width-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf, special;
    logic [width-1:0] special_result;

    assign rs1_signed = (MulCtrl == 3'b001) || (MulCtrl == 3'b010) ||
                        (MulCtrl == 3'b100) || (MulCtrl == 3'b110);
    assign rs2_signed = (MulCtrl == 3'b001) || (MulCtrl == 3'b100) || (MulCtrl == 3'b110);
    assign sign_a     = rs1_signed && rs1[width-1];
    assign sign_b     = rs2_signed && rs2_MUX[width-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a      = sign_a ? -rs1 : rs1;
    assign mag_b      = sign_b ? -rs2_MUX : rs2_MUX;

    assign div_zero = MulCtrl[2] && (rs2_MUX == '0);
    assign div_ovf  = ((MulCtrl == 3'b100) || (MulCtrl == 3'b110)) &&
                      (rs1 == {1'b1, {(width-1){1'b0}}}) && (rs2_MUX == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = MulCtrl[1] ? rs1 : '1;
        else if (div_ovf)
            special_result = MulCtrl[1] ? '0 : rs1;
    end

    // One iteration step of either algorithm
    logic [width:0]   mul_sum;
    logic [width:0]   div_shift, div_diff;
    logic             div_borrow;

    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift  = {acc_hi, acc_lo[width-1]};
    assign div_diff   = div_shift - {1'b0, opnd};
    assign div_borrow = div_diff[width];

    // Sign correction and result selection
    logic [2*width-1:0] prod_s;
    logic [width-1:0]   quot_s, rem_s, fix_result;

    assign prod_s = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_s = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    assign rem_s  = neg_a ? -acc_hi : acc_hi;

    always_comb begin
        fix_result = '0;
        case (op_q)
            3'b000:                 fix_result = prod_s[width-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_s[2*width-1:width];
            3'b100, 3'b101:         fix_result = quot_s;
            default:                fix_result = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = special ? DONE : CALC;
            end
            CALC: begin
                if (cnt == '0)
                    state_next = FIX;
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            result      <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= MulCtrl;
                        neg_a  <= sign_a;
                        neg_b  <= sign_b;
                        opnd   <= MulCtrl[2] ? mag_b : mag_a;
                        acc_hi <= '0;
                        acc_lo <= MulCtrl[2] ? mag_a : mag_b;
                        cnt    <= cw'(width - 1);
                        if (special) begin
                            result      <= special_result;
                            zero        <= (special_result == '0);
                            div_by_zero <= div_zero;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (op_q[2]) begin
                        acc_hi <= div_borrow ? div_shift[width-1:0] : div_diff[width-1:0];
                        acc_lo <= {acc_lo[width-2:0], ~div_borrow};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[width-1:1]};
                    end
                end
                FIX: begin
                    result      <= fix_result;
                    zero        <= (fix_result == '0);
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2_MUX;
    logic [2:0]  MulCtrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int lat_full    = 33;
    localparam int lat_special = 0;

    muldiv_seq #(.width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2_MUX    (rs2_MUX),
        .MulCtrl    (MulCtrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Latency is the number of edges after the accept edge before out_valid is seen.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic ez, input logic edbz,
                          input int elat, input int hold, input bit noise);
        int lat;
        @(negedge clk);
        rs1 = a; rs2_MUX = b; MulCtrl = op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        check({tag, ".busy"}, {31'b0, in_ready}, 32'd0);
        in_valid = noise; rs1 = $urandom; rs2_MUX = $urandom; MulCtrl = 3'($urandom);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (noise) begin
                rs1 = $urandom; rs2_MUX = $urandom; MulCtrl = 3'($urandom);
            end
        end
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".res"}, result, exp);
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, ez});
        check({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_v"}, {31'b0, out_valid}, 32'd1);
            check({tag, ".hold_r"}, result, exp);
            check({tag, ".hold_z"}, {31'b0, zero}, {31'b0, ez});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check({tag, ".rel_v"}, {31'b0, out_valid}, 32'd0);
        check({tag, ".rel_rdy"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2_MUX = '0; MulCtrl = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.rdy",  {31'b0, in_ready},    32'd1);
        check("rst.v",    {31'b0, out_valid},   32'd0);
        check("rst.res",  result,               32'd0);
        check("rst.zero", {31'b0, zero},        32'd0);
        check("rst.dbz",  {31'b0, div_by_zero}, 32'd0);
        rst = 1'b0;

        run_op("mul5x3",   3'b000, 32'h5,        32'h3,        32'h0000000F, 1'b0, 1'b0, lat_full, 0, 1'b0);
        run_op("mulh",     3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, lat_full, 0, 1'b0);
        run_op("mulhsu",   3'b010, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, lat_full, 0, 1'b0);
        run_op("mulhu",    3'b011, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 1'b0, 1'b0, lat_full, 0, 1'b0);
        run_op("mul_lo",   3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, 1'b0, lat_full, 5, 1'b0);
        run_op("mul_zero", 3'b000, 32'h0,        32'h12345678, 32'h0,        1'b1, 1'b0, lat_full, 0, 1'b0);
        run_op("div_neg",  3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 1'b0, lat_full, 0, 1'b0);
        run_op("rem_neg",  3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, 1'b0, lat_full, 0, 1'b0);
        run_op("divu",     3'b101, 32'hA,        32'h3,        32'h3,        1'b0, 1'b0, lat_full, 0, 1'b1);
        run_op("remu",     3'b111, 32'hA,        32'h3,        32'h1,        1'b0, 1'b0, lat_full, 0, 1'b0);
        run_op("rem7",     3'b110, 32'h7,        32'h7,        32'h0,        1'b1, 1'b0, lat_full, 0, 1'b0);
        run_op("divu_z",   3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1'b0, 1'b1, lat_special, 0, 1'b0);
        run_op("rem_z",    3'b110, 32'h1234,     32'h0,        32'h00001234, 1'b0, 1'b1, lat_special, 0, 1'b0);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, lat_special, 0, 1'b0);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, lat_special, 3, 1'b1);

        // Reset during CALC cycle 10 aborts the operation.
        @(negedge clk);
        rs1 = 32'h9; rs2_MUX = 32'h9; MulCtrl = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst.rdy", {31'b0, in_ready},  32'd1);
        check("midrst.v",   {31'b0, out_valid}, 32'd0);
        check("midrst.res", result,             32'd0);

        run_op("mul7x6", 3'b000, 32'h7, 32'h6, 32'h0000002A, 1'b0, 1'b0, lat_full, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
